load_store_unit: RTL and testbench

//  Memory stage downstream of the ALU: consumes the ALU result as a byte address for LW/LBU/SW/SB.

---
 rtl/load_store_unit_pkg.sv | 34 +++
 rtl/load_store_unit_if.sv | 14 +
 rtl/load_store_unit_byte_lane.sv | 33 +++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared load/store unit definitions: operation and state encodings, word mask, op classifiers.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_LW   = 3'd1,
    OP_LBU  = 3'd2,
    OP_SW   = 3'd3,
    OP_SB   = 3'd4
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [3:0] kWORD_MASK = 4'hF;

  // Undefined encodings (5..7) are treated like NONE.
  function automatic logic is_mem_op(lsu_op_e op);
    return (op == OP_LW) || (op == OP_LBU) || (op == OP_SW) || (op == OP_SB);
  endfunction

  function automatic logic is_store(lsu_op_e op);
    return (op == OP_SW) || (op == OP_SB);
  endfunction

  function automatic logic is_word_op(lsu_op_e op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port: valid/yumi request channel plus response-valid read channel.
interface load_store_unit_if;
  logic        v;
  logic [29:0] addr;
  logic        we;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic        yumi;
  logic        rsp_v;
  logic [31:0] rdata;

  modport master (output v, addr, we, mask, wdata, input yumi, rsp_v, rdata);
  modport slave  (input v, addr, we, mask, wdata, output yumi, rsp_v, rdata);
endinterface

// File: rtl/load_store_unit_byte_lane.sv
// Combinational byte-lane steering: SB mask/replication and LBU byte extract with zero-extension.
module lsu_byte_lane
  import load_store_unit_pkg::*;
(
  input  lsu_op_e     op,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0] rbyte [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rbyte[gi] = rdata[8*gi +: 8];
  end

  always_comb begin
    mask      = kWORD_MASK;
    wdata     = store_data;
    load_data = rdata;
    if (op == OP_SB) begin
      mask  = 4'b0001 << byte_sel;
      wdata = {4{store_data[7:0]}};
    end
    if (op == OP_LBU) begin
      load_data = {24'h0, rbyte[byte_sel]};
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage LSU: one data-memory access at a time, stalls the core until it completes.
// Optional abort timer enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        valid_i,
  input  lsu_op_e     op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        stall_o,
  output logic        load_v_o,
  output logic [31:0] load_data_o,
  output logic        err_o,
  load_store_unit_if.master mem
);

  lsu_state_e  state_reg, state_next;
  lsu_op_e     op_reg, op_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] sdata_reg, sdata_next;
  logic [31:0] result_reg, result_next;
  logic        err_reg, err_next;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata, lane_load;
  logic        timeout_hit;

  lsu_byte_lane u_byte_lane (
    .op        (op_reg),
    .byte_sel  (addr_reg[1:0]),
    .store_data(sdata_reg),
    .rdata     (mem.rdata),
    .mask      (lane_mask),
    .wdata     (lane_wdata),
    .load_data (lane_load)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Counter holds the number of REQ/WAIT cycles already spent before the current one.
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_next = cnt_reg;
    if (state_next == ST_REQ && state_reg != ST_REQ) begin
      cnt_next = '0;
    end else if (state_reg == ST_REQ || state_reg == ST_WAIT) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) cnt_reg <= '0;
    else          cnt_reg <= cnt_next;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg  <= ST_IDLE;
      op_reg     <= OP_NONE;
      addr_reg   <= '0;
      sdata_reg  <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      addr_reg   <= addr_next;
      sdata_reg  <= sdata_next;
      result_reg <= result_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    addr_next   = addr_reg;
    sdata_next  = sdata_reg;
    result_next = result_reg;
    err_next    = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (valid_i && is_mem_op(op_i)) begin
          op_next     = op_i;
          addr_next   = addr_i;
          sdata_next  = store_data_i;
          result_next = '0;
          err_next    = is_word_op(op_i) && (addr_i[1:0] != 2'b00);
          state_next  = err_next ? ST_DONE : ST_REQ;
        end
      end
      // A handshake landing on the last allowed cycle wins over the abort.
      ST_REQ: begin
        if (mem.yumi) begin
          state_next = is_store(op_reg) ? ST_DONE : ST_WAIT;
        end else if (timeout_hit) begin
          state_next = ST_DONE;
          err_next   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (mem.rsp_v) begin
          result_next = lane_load;
          state_next  = ST_DONE;
        end else if (timeout_hit) begin
          state_next = ST_DONE;
          err_next   = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_o     = 1'b1;
    load_v_o    = 1'b0;
    err_o       = 1'b0;
    load_data_o = '0;
    mem.v       = 1'b0;
    mem.addr    = '0;
    mem.we      = 1'b0;
    mem.mask    = '0;
    mem.wdata   = '0;
    case (state_reg)
      ST_IDLE: stall_o = n_reset && valid_i && is_mem_op(op_i);
      ST_REQ: begin
        mem.v     = 1'b1;
        mem.addr  = addr_reg[31:2];
        mem.we    = is_store(op_reg);
        mem.mask  = lane_mask;
        mem.wdata = lane_wdata;
      end
      ST_DONE: begin
        stall_o     = 1'b0;
        load_v_o    = 1'b1;
        err_o       = err_reg;
        load_data_o = result_reg;
      end
      default: stall_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized ops against a byte-level model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

`ifdef LSU_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
  localparam int SB_HOLD    = 3;
  localparam int MAX_DLY    = 1;
`else
  localparam int TB_TIMEOUT = 255;
  localparam int SB_HOLD    = 5;
  localparam int MAX_DLY    = 3;
`endif

  logic        clk = 1'b0;
  logic        n_reset;
  logic        valid_i;
  lsu_op_e     op_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic        stall_o;
  logic        load_v_o;
  logic [31:0] load_data_o;
  logic        err_o;
  int          checks   = 0;
  int          failures = 0;

  load_store_unit_if mem_bus ();

  load_store_unit #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .valid_i     (valid_i),
    .op_i        (op_i),
    .addr_i      (addr_i),
    .store_data_i(store_data_i),
    .stall_o     (stall_o),
    .load_v_o    (load_v_o),
    .load_data_o (load_data_o),
    .err_o       (err_o),
    .mem         (mem_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference rules, stated in terms of byte offsets rather than lane logic.
  function automatic logic [3:0] ref_mask(lsu_op_e op, logic [31:0] a);
    int sh = int'(a % 4);
    return (op == OP_SB) ? 4'(1 << sh) : 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(lsu_op_e op, logic [31:0] sd);
    return (op == OP_SB) ? (sd & 32'hFF) * 32'h0101_0101 : sd;
  endfunction

  function automatic logic [31:0] ref_load(lsu_op_e op, logic [31:0] a, logic [31:0] rd);
    int sh = 8 * int'(a % 4);
    return (op == OP_LBU) ? ((rd >> sh) & 32'hFF) : rd;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction from the IDLE accept cycle through the following IDLE cycle.
  task automatic run_op(input lsu_op_e op, input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rdata, input int yd, input int rd, input bit stray);
    bit          mis = (op == OP_LW || op == OP_SW) && (a % 4 != 0);
    bit          st  = (op == OP_SW || op == OP_SB);
    logic [31:0] exp_data = (mis || st) ? 32'h0 : ref_load(op, a, rdata);
    valid_i = 1'b1; op_i = op; addr_i = a; store_data_i = sd;
    mem_bus.yumi = 1'b0; mem_bus.rsp_v = 1'b0;
    @(negedge clk);
    check("accept_stall", stall_o, 1);
    check("accept_mem_v", mem_bus.v, 0);
    next_cycle();
    op_i = lsu_op_e'($urandom_range(0, 4)); addr_i = $urandom; store_data_i = $urandom;
    if (!mis) begin
      for (int k = 0; k <= yd; k++) begin
        mem_bus.yumi  = (k == yd);
        mem_bus.rsp_v = stray && (k == 0);
        mem_bus.rdata = $urandom;
        @(negedge clk);
        check("req_v", mem_bus.v, 1);
        check("req_addr", {2'b00, mem_bus.addr}, {2'b00, a[31:2]});
        check("req_we", mem_bus.we, st);
        check("req_mask", mem_bus.mask, ref_mask(op, a));
        check("req_wdata", mem_bus.wdata, ref_wdata(op, sd));
        check("req_stall", stall_o, 1);
        check("req_load_v", load_v_o, 0);
        next_cycle();
      end
      mem_bus.yumi = 1'b0; mem_bus.rsp_v = 1'b0;
      if (!st) begin
        for (int k = 0; k <= rd; k++) begin
          mem_bus.rsp_v = (k == rd);
          mem_bus.rdata = (k == rd) ? rdata : $urandom;
          @(negedge clk);
          check("wait_mem_v", mem_bus.v, 0);
          check("wait_stall", stall_o, 1);
          check("wait_load_v", load_v_o, 0);
          next_cycle();
        end
        mem_bus.rsp_v = 1'b0; mem_bus.rdata = $urandom;
      end
    end
    @(negedge clk);
    check("done_load_v", load_v_o, 1);
    check("done_stall", stall_o, 0);
    check("done_err", err_o, mis);
    check("done_data", load_data_o, exp_data);
    check("done_mem_v", mem_bus.v, 0);
    next_cycle();
    valid_i = 1'b0; op_i = OP_NONE;
    mem_bus.rsp_v = 1'b1; mem_bus.rdata = $urandom;
    @(negedge clk);
    check("idle_load_v", load_v_o, 0);
    check("idle_stall", stall_o, 0);
    check("idle_mem_v", mem_bus.v, 0);
    next_cycle();
    mem_bus.rsp_v = 1'b0;
    $display("txn op=%s addr=%h sdata=%h rdata=%h yumi_dly=%0d rsp_dly=%0d exp_data=%h exp_err=%0d",
             op.name(), a, sd, rdata, yd, rd, exp_data, mis);
  endtask

  initial begin
    lsu_op_e     rop;
    logic [31:0] ra;
    n_reset = 1'b0; valid_i = 1'b0; op_i = OP_NONE; addr_i = '0; store_data_i = '0;
    mem_bus.yumi = 1'b0; mem_bus.rsp_v = 1'b1; mem_bus.rdata = 32'hCAFE_F00D;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", stall_o, 0);
    check("rst_load_v", load_v_o, 0);
    check("rst_err", err_o, 0);
    check("rst_data", load_data_o, 0);
    check("rst_mem_v", mem_bus.v, 0);
    check("rst_mem_mask", mem_bus.mask, 0);
    next_cycle();
    n_reset = 1'b1;
    @(negedge clk);
    check("post_rst_stale_rsp_load_v", load_v_o, 0);
    check("post_rst_mem_v", mem_bus.v, 0);
    next_cycle();
    mem_bus.rsp_v = 1'b0;

    run_op(OP_LW, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
    run_op(OP_LBU, 32'h0000_0103, 32'h0, 32'hAABB_CCDD, 0, 0, 1'b0);
    run_op(OP_SB, 32'h0000_0102, 32'h1234_5677, 32'h0, SB_HOLD, 0, 1'b0);
    run_op(OP_SW, 32'h0000_0101, 32'h5555_AAAA, 32'h0, 0, 0, 1'b0);
    run_op(OP_LW, 32'h0000_0202, 32'h0, 32'h0, 0, 0, 1'b0);
    run_op(OP_LBU, 32'h0000_0001, 32'h0, 32'h1122_3344, 1, 1, 1'b1);

    // Reset while waiting for read data, with a response arriving during/after reset.
    valid_i = 1'b1; op_i = OP_LW; addr_i = 32'h0000_0300;
    next_cycle();
    mem_bus.yumi = 1'b1;
    next_cycle();
    mem_bus.yumi = 1'b0;
    n_reset = 1'b0;
    #1;
    check("rst_wait_mem_v", mem_bus.v, 0);
    check("rst_wait_load_v", load_v_o, 0);
    check("rst_wait_stall", stall_o, 0);
    mem_bus.rsp_v = 1'b1; mem_bus.rdata = 32'h0BAD_0BAD; valid_i = 1'b0;
    next_cycle();
    n_reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_wait_after_load_v", load_v_o, 0);
      check("rst_wait_after_mem_v", mem_bus.v, 0);
      next_cycle();
    end
    mem_bus.rsp_v = 1'b0;

    // Reset while a request is outstanding drops mem_v without a clock edge.
    valid_i = 1'b1; op_i = OP_SW; addr_i = 32'h0000_0400; store_data_i = 32'h8765_4321;
    next_cycle();
    check("rst_req_pre_mem_v", mem_bus.v, 1);
    n_reset = 1'b0;
    #1;
    check("rst_req_async_mem_v", mem_bus.v, 0);
    check("rst_req_async_mask", mem_bus.mask, 0);
    valid_i = 1'b0;
    next_cycle();
    n_reset = 1'b1;
    @(negedge clk);
    check("rst_req_after_load_v", load_v_o, 0);
    next_cycle();

    run_op(OP_LW, 32'h0000_0500, 32'h0, 32'h0F0F_1234, 0, 0, 1'b0);

`ifdef LSU_TIMEOUT_EN
    // No yumi: aborts after TB_TIMEOUT REQ cycles with an error completion.
    valid_i = 1'b1; op_i = OP_LW; addr_i = 32'h0000_0200;
    next_cycle();
    valid_i = 1'b0; op_i = OP_NONE;
    for (int k = 0; k < TB_TIMEOUT; k++) begin
      @(negedge clk);
      check("to_req_v", mem_bus.v, 1);
      check("to_req_load_v", load_v_o, 0);
      next_cycle();
    end
    @(negedge clk);
    check("to_done_load_v", load_v_o, 1);
    check("to_done_err", err_o, 1);
    check("to_done_data", load_data_o, 0);
    check("to_done_mem_v", mem_bus.v, 0);
    next_cycle();
    mem_bus.rsp_v = 1'b1; mem_bus.rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("to_late_rsp_load_v", load_v_o, 0);
    check("to_late_rsp_mem_v", mem_bus.v, 0);
    next_cycle();
    mem_bus.rsp_v = 1'b0;
`endif

    for (int t = 0; t < 40; t++) begin
      rop = lsu_op_e'($urandom_range(1, 4));
      ra  = $urandom;
      if ((rop == OP_LW || rop == OP_SW) && $urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      run_op(rop, ra, $urandom, $urandom, int'($urandom_range(0, MAX_DLY)),
             int'($urandom_range(0, MAX_DLY)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
